// File: rtl/sr_reg_bank.sv
// Bank of WIDTH independent storage bits with runtime-selectable SR/JK/D/T behaviour.
// SR-mode s=r=1 conflicts resolve per CONFLICT_POLICY and feed a per-bit vector, a sticky flag and a saturating counter.
module sr_reg_bank #(
    parameter int unsigned       WIDTH           = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL       = '0,
    parameter int unsigned       CONFLICT_POLICY = 0,
    parameter int unsigned       CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] conflict_vec,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        MODE_SR = 2'b00,
        MODE_JK = 2'b01,
        MODE_D  = 2'b10,
        MODE_T  = 2'b11
    } mode_e;

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] cv_q, cv_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] conflict_next;
    logic             conflict_evt;
    mode_e            mode_sel;

    assign mode_sel = mode_e'(mode);

    always_comb begin
        q_next = q_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            unique case (mode_sel)
                MODE_SR: begin
                    unique case ({s[i], r[i]})
                        2'b00: q_next[i] = q_q[i];
                        2'b01: q_next[i] = 1'b0;
                        2'b10: q_next[i] = 1'b1;
                        default: begin
                            unique case (CONFLICT_POLICY)
                                1:       q_next[i] = 1'b1;
                                2:       q_next[i] = 1'b0;
                                3:       q_next[i] = ~q_q[i];
                                default: q_next[i] = q_q[i];
                            endcase
                        end
                    endcase
                end
                MODE_JK: begin
                    unique case ({s[i], r[i]})
                        2'b00:   q_next[i] = q_q[i];
                        2'b01:   q_next[i] = 1'b0;
                        2'b10:   q_next[i] = 1'b1;
                        default: q_next[i] = ~q_q[i];
                    endcase
                end
                MODE_D:  q_next[i] = s[i];
                default: q_next[i] = q_q[i] ^ s[i];
            endcase
        end
    end

    assign conflict_next = (mode_sel == MODE_SR) ? (s & r) : '0;
    assign conflict_evt  = en && (|conflict_next);

    // A conflict on the same edge as clr_err wins: the clear is applied first, then the event.
    always_comb begin
        q_d      = q_q;
        cv_d     = cv_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (en) begin
            q_d  = q_next;
            cv_d = conflict_next;
        end
        if (clr_err) begin
            cv_d     = en ? conflict_next : '0;
            sticky_d = 1'b0;
            cnt_d    = '0;
        end
        if (conflict_evt) begin
            sticky_d = 1'b1;
            if (clr_err)
                cnt_d = CNT_W'(1);
            else if (&cnt_q)
                cnt_d = cnt_q;
            else
                cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q      <= RESET_VAL;
            cv_q     <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            q_q      <= q_d;
            cv_q     <= cv_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign q            = q_q;
    assign qb           = ~q_q;
    assign conflict_vec = cv_q;
    assign err_sticky   = sticky_q;
    assign err_cnt      = cnt_q;

endmodule

// File: tb/tb_sr_reg_bank.sv
// Four instances (one per conflict policy, instance 0 with a 2-bit counter) driven in lockstep
// and compared against an arithmetic per-bit reference model.
module tb_sr_reg_bank;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [7:0] s;
    logic [7:0] r;
    logic       clr_err;

    logic [7:0]  q_a   [4];
    logic [7:0]  qb_a  [4];
    logic [7:0]  cv_a  [4];
    logic        st_a  [4];
    logic [31:0] cnt_a [4];

    int m_q   [4];
    int m_cv  [4];
    int m_st  [4];
    int m_cnt [4];

    int checks;
    int errors;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned CW = (g == 0) ? 2 : 8;
        logic [7:0]    q_w, qb_w, cv_w;
        logic          st_w;
        logic [CW-1:0] cnt_w;

        sr_reg_bank #(
            .WIDTH(8),
            .RESET_VAL(8'hA5),
            .CONFLICT_POLICY(g),
            .CNT_W(CW)
        ) u_dut (
            .clk(clk),
            .rst_n(rst_n),
            .en(en),
            .mode(mode),
            .s(s),
            .r(r),
            .clr_err(clr_err),
            .q(q_w),
            .qb(qb_w),
            .conflict_vec(cv_w),
            .err_sticky(st_w),
            .err_cnt(cnt_w)
        );

        assign q_a[g]   = q_w;
        assign qb_a[g]  = qb_w;
        assign cv_a[g]  = cv_w;
        assign st_a[g]  = st_w;
        assign cnt_a[g] = 32'(cnt_w);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cnt_max(input int g);
        return (g == 0) ? 3 : 255;
    endfunction

    function automatic int model_next(input int pol, input int md, input int qv, input int sv, input int rv);
        int res = 0;
        for (int b = 0; b < 8; b++) begin
            int qbit = (qv >> b) & 1;
            int sbit = (sv >> b) & 1;
            int rbit = (rv >> b) & 1;
            int nb;
            case (md)
                0: begin
                    if (sbit == 1 && rbit == 1)
                        nb = (pol == 1) ? 1 : (pol == 2) ? 0 : (pol == 3) ? 1 - qbit : qbit;
                    else
                        nb = (sbit == 1) ? 1 : (rbit == 1) ? 0 : qbit;
                end
                1: nb = (sbit == 1 && rbit == 1) ? 1 - qbit : (sbit == 1) ? 1 : (rbit == 1) ? 0 : qbit;
                2: nb = sbit;
                default: nb = qbit ^ sbit;
            endcase
            res = res | (nb << b);
        end
        return res;
    endfunction

    task automatic model_reset();
        for (int g = 0; g < 4; g++) begin
            m_q[g] = 'hA5; m_cv[g] = 0; m_st[g] = 0; m_cnt[g] = 0;
        end
    endtask

    task automatic model_edge(input int e, input int md, input int sv, input int rv, input int c);
        int newcv = (md == 0) ? (sv & rv) : 0;
        int evt   = (e != 0 && newcv != 0) ? 1 : 0;
        for (int g = 0; g < 4; g++) begin
            if (e != 0) begin
                m_q[g]  = model_next(g, md, m_q[g], sv, rv);
                m_cv[g] = newcv;
            end else if (c != 0) begin
                m_cv[g] = 0;
            end
            if (c != 0) begin
                m_st[g]  = evt;
                m_cnt[g] = evt;
            end else if (evt != 0) begin
                m_st[g]  = 1;
                m_cnt[g] = (m_cnt[g] < cnt_max(g)) ? m_cnt[g] + 1 : m_cnt[g];
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("%s/p%0d/q", tag, g),      32'(q_a[g]),  32'(m_q[g]));
            chk($sformatf("%s/p%0d/qb", tag, g),     32'(qb_a[g]), 32'((~m_q[g]) & 'hFF));
            chk($sformatf("%s/p%0d/cv", tag, g),     32'(cv_a[g]), 32'(m_cv[g]));
            chk($sformatf("%s/p%0d/sticky", tag, g), 32'(st_a[g]), 32'(m_st[g]));
            chk($sformatf("%s/p%0d/cnt", tag, g),    cnt_a[g],     32'(m_cnt[g]));
        end
    endtask

    task automatic step(input logic e, input logic [1:0] md, input logic [7:0] sv, input logic [7:0] rv,
                        input logic c, input string tag);
        @(negedge clk);
        en = e; mode = md; s = sv; r = rv; clr_err = c;
        @(posedge clk);
        model_edge(int'(e), int'(md), int'(sv), int'(rv), int'(c));
        #1;
        check_all(tag);
    endtask

    task automatic reset_pulse(input string tag);
        #1 rst_n = 1'b0;
        #1 model_reset();
        check_all(tag);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b1; en = 1'b0; mode = 2'b00; s = '0; r = '0; clr_err = 1'b0;
        model_reset();

        #2 rst_n = 1'b0;
        #1 check_all("reset");
        #1 rst_n = 1'b1;

        step(1'b1, 2'b00, 8'h0F, 8'hF0, 1'b0, "sr_basic");
        step(1'b1, 2'b00, 8'h00, 8'h00, 1'b0, "sr_hold");
        step(1'b1, 2'b00, 8'h11, 8'h11, 1'b0, "sr_conflict");

        step(1'b1, 2'b10, 8'h0F, 8'h00, 1'b0, "d_resync");
        step(1'b1, 2'b01, 8'hFF, 8'hFF, 1'b0, "jk_toggle");
        step(1'b1, 2'b10, 8'h3C, 8'h55, 1'b0, "d_load");
        step(1'b1, 2'b11, 8'hFF, 8'hFF, 1'b0, "t_toggle");
        step(1'b0, 2'b00, 8'hFF, 8'hFF, 1'b0, "en_low_hold");

        step(1'b1, 2'b00, 8'h81, 8'h83, 1'b0, "sat_2");
        step(1'b1, 2'b00, 8'h02, 8'h06, 1'b0, "sat_3");
        step(1'b1, 2'b00, 8'hFF, 8'hFF, 1'b0, "sat_hold");
        step(1'b1, 2'b00, 8'h40, 8'h40, 1'b1, "clr_with_conflict");
        step(1'b0, 2'b00, 8'h00, 8'h00, 1'b1, "clr_en_low");
        step(1'b1, 2'b00, 8'h0C, 8'h0C, 1'b0, "conflict_again");
        step(1'b1, 2'b01, 8'hFF, 8'hFF, 1'b1, "clr_alone");

        step(1'b1, 2'b11, 8'h5A, 8'h00, 1'b0, "t_seq0");
        step(1'b1, 2'b11, 8'hFF, 8'h00, 1'b0, "t_seq1");
        reset_pulse("reset_mid");
        step(1'b1, 2'b11, 8'hFF, 8'h00, 1'b0, "t_after_reset");

        for (int i = 0; i < 150; i++) begin
            logic       e;
            logic [1:0] md;
            logic [7:0] sv, rv;
            logic       c;
            e  = ($urandom_range(0, 5) != 0);
            md = 2'($urandom_range(0, 3));
            sv = 8'($urandom);
            rv = 8'($urandom);
            c  = ($urandom_range(0, 9) == 0);
            step(e, md, sv, rv, c, $sformatf("rand%0d", i));
            if (i % 37 == 20) reset_pulse($sformatf("rand_reset%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sr_reg_bank.md
Name: sr_reg_bank

Overview:
- WIDTH-bit bank of independent set/reset storage elements with a shared clock, enable and runtime-selectable mode: SR, JK, D or T.
- Replaces single-bit SR flip-flops in control paths that need many flags.
- Resolves the S=R=1 case deterministically instead of going to X, and reports conflicts through a per-bit vector, a sticky flag and a saturating counter.

Parameters:
WIDTH, 8, number of storage bits (1..32)
RESET_VAL, all zeros, q value loaded on reset (WIDTH bits)
CONFLICT_POLICY, 0, SR-mode action on s=r=1: 0 hold, 1 set wins, 2 reset wins, 3 toggle
CNT_W, 8, width of conflict counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  update enable; 0 holds all state except error clear
mode  input  2  00 SR, 01 JK, 10 D, 11 T
s  input  WIDTH  set / J / D / T per bit
r  input  WIDTH  reset / K per bit; ignored in D and T modes
clr_err  input  1  synchronous clear of err_sticky, conflict_vec and err_cnt
q  output  WIDTH  stored state
qb  output  WIDTH  always exactly ~q, never X
conflict_vec  output  WIDTH  bits that saw s=r=1 in SR mode on the last enabled edge
err_sticky  output  1  set on any SR-mode conflict; holds until clr_err
err_cnt  output  CNT_W  count of clock edges with at least one conflict; saturates at all-ones

Behaviour:
- Reset: rst_n low asynchronously forces the following, regardless of clk. Release is synchronous to the next edge with no extra latency.
  - q=RESET_VAL, qb=~RESET_VAL
  - conflict_vec=0, err_sticky=0, err_cnt=0
- Latency: outputs update on the clk rising edge after inputs are sampled. No combinational path from inputs to outputs. qb is derived from the q register.
- en=0: q, conflict_vec and err_cnt hold. clr_err still acts.
- Per-bit next state with en=1:
  - SR mode: 00 hold; 01 q=0; 10 q=1; 11 per CONFLICT_POLICY.
  - JK mode: 00 hold; 01 q=0; 10 q=1; 11 toggle. Not a conflict.
  - D mode: q=s.
  - T mode: q = q XOR s.
- conflict_vec: on each enabled edge, loaded with (s AND r) in SR mode, else 0.
- Conflict event: an enabled SR-mode edge with conflict_vec_next nonzero.
  - Sets err_sticky.
  - Increments err_cnt by 1 per edge, not per bit. Saturates at 2^CNT_W-1 with no wrap.
- clr_err with a simultaneous conflict event on the same edge: the new event wins. Result is err_sticky=1, err_cnt=1, and conflict_vec loads the new vector.
- clr_err alone: err_sticky=0, err_cnt=0, conflict_vec=0 on that edge.
- Mode changes take effect on the same edge they are sampled. No pipeline, no internal state carried across modes other than q.
- Reset mid-operation: state goes to reset values immediately. The first edge after release evaluates normally from RESET_VAL.
- All bits are independent; no cross-bit interaction except in the error aggregation.

Test Plan:
1. Reset: WIDTH=8, RESET_VAL=8'hA5; assert rst_n=0 between edges -> q=A5 and qb=5A immediately; err_cnt=0, err_sticky=0.
2. SR basic: mode=00, en=1, s=8'h0F, r=8'hF0 from q=A5 -> q=0F, qb=F0 next edge. Then s=r=0 -> q holds 0F.
3. Conflict policy: q=0F, s=r=8'h11.
   - POLICY=0 -> q=0F.
   - POLICY=1 -> q=1F.
   - POLICY=2 -> q=0E.
   - POLICY=3 -> q=1E.
   - All policies: conflict_vec=11, err_sticky=1, err_cnt increments by 1.
4. JK/D/T:
   - JK with j=k=FF from 0F -> F0, with no error change.
   - D with s=3C -> 3C.
   - T with s=FF from 3C -> C3.
   - en=0 with any inputs -> q holds.
5. Counter saturation: CNT_W=2, four consecutive conflict edges -> err_cnt goes 1,2,3,3. Then clr_err with a simultaneous conflict -> err_cnt=1, err_sticky=1.
6. Async reset mid-stream: rst_n pulsed low during a T-mode toggle sequence, not aligned to clk -> q=RESET_VAL and err_cnt=0 immediately. Toggling resumes from RESET_VAL on the first edge after release.
